// File: rtl/resp_demux_m4_if.sv
// Slave-side B and R response bundle feeding resp_demux_m4.
// The interconnect drives it through the master modport, and the demux consumes it through the slave modport.
interface resp_demux_m4_if #(
    parameter int DATA_W = 32
);
    logic [5:0]        bid_s;
    logic [1:0]        bresp_s;
    logic              bvalid_s;
    logic              bready_s;
    logic [5:0]        rid_s;
    logic [DATA_W-1:0] rdata_s;
    logic [1:0]        rresp_s;
    logic              rlast_s;
    logic              rvalid_s;
    logic              rready_s;

    modport master (
        output bid_s, bresp_s, bvalid_s, rid_s, rdata_s, rresp_s, rlast_s, rvalid_s,
        input  bready_s, rready_s
    );

    modport slave (
        input  bid_s, bresp_s, bvalid_s, rid_s, rdata_s, rresp_s, rlast_s, rvalid_s,
        output bready_s, rready_s
    );
endinterface

// File: rtl/resp_demux_m4.sv
// Routes one slave's B and R response channels to four masters.
// Routing uses id[5:4], and each channel has its own single-entry register stage.
module resp_demux_m4 #(
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [5:0]        bid_s,
    input  logic [1:0]        bresp_s,
    input  logic              bvalid_s,
    output logic              bready_s,
    input  logic [5:0]        rid_s,
    input  logic [DATA_W-1:0] rdata_s,
    input  logic [1:0]        rresp_s,
    input  logic              rlast_s,
    input  logic              rvalid_s,
    output logic              rready_s,
    output logic [3:0]        bid_m1,
    output logic [1:0]        bresp_m1,
    output logic              bvalid_m1,
    input  logic              bready_m1,
    output logic [3:0]        bid_m2,
    output logic [1:0]        bresp_m2,
    output logic              bvalid_m2,
    input  logic              bready_m2,
    output logic [3:0]        bid_m3,
    output logic [1:0]        bresp_m3,
    output logic              bvalid_m3,
    input  logic              bready_m3,
    output logic [3:0]        bid_m4,
    output logic [1:0]        bresp_m4,
    output logic              bvalid_m4,
    input  logic              bready_m4,
    output logic [3:0]        rid_m1,
    output logic [DATA_W-1:0] rdata_m1,
    output logic [1:0]        rresp_m1,
    output logic              rlast_m1,
    output logic              rvalid_m1,
    input  logic              rready_m1,
    output logic [3:0]        rid_m2,
    output logic [DATA_W-1:0] rdata_m2,
    output logic [1:0]        rresp_m2,
    output logic              rlast_m2,
    output logic              rvalid_m2,
    input  logic              rready_m2,
    output logic [3:0]        rid_m3,
    output logic [DATA_W-1:0] rdata_m3,
    output logic [1:0]        rresp_m3,
    output logic              rlast_m3,
    output logic              rvalid_m3,
    input  logic              rready_m3,
    output logic [3:0]        rid_m4,
    output logic [DATA_W-1:0] rdata_m4,
    output logic [1:0]        rresp_m4,
    output logic              rlast_m4,
    output logic              rvalid_m4,
    input  logic              rready_m4
);
    logic              b_full_q, b_full_d;
    logic [1:0]        b_dst_q, b_dst_d;
    logic [3:0]        b_id_q, b_id_d;
    logic [1:0]        b_resp_q, b_resp_d;
    logic              b_dst_rdy_s, b_cap_s, b_drain_s;

    logic              r_full_q, r_full_d;
    logic [1:0]        r_dst_q, r_dst_d;
    logic [3:0]        r_id_q, r_id_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic [1:0]        r_resp_q, r_resp_d;
    logic              r_last_q, r_last_d;
    logic              r_dst_rdy_s, r_cap_s, r_drain_s;

    // Only the stored destination's ready can free the B stage.
    always_comb begin
        b_dst_rdy_s = 1'b0;
        case (b_dst_q)
            2'd0:    b_dst_rdy_s = bready_m1;
            2'd1:    b_dst_rdy_s = bready_m2;
            2'd2:    b_dst_rdy_s = bready_m3;
            2'd3:    b_dst_rdy_s = bready_m4;
            default: b_dst_rdy_s = 1'b0;
        endcase
    end

    assign b_drain_s = b_full_q & b_dst_rdy_s;
    assign bready_s  = ~b_full_q | b_dst_rdy_s;
    assign b_cap_s   = bvalid_s & bready_s;

    // B stage next state: a capture overwrites, so simultaneous drain and capture keep the stage full.
    always_comb begin
        b_full_d = b_full_q;
        b_dst_d  = b_dst_q;
        b_id_d   = b_id_q;
        b_resp_d = b_resp_q;
        if (b_cap_s) begin
            b_full_d = 1'b1;
            b_dst_d  = bid_s[5:4];
            b_id_d   = bid_s[3:0];
            b_resp_d = bresp_s;
        end else if (b_drain_s) begin
            b_full_d = 1'b0;
        end else begin
            b_full_d = b_full_q;
        end
    end

    // B stage register.
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            b_full_q <= 1'b0;
            b_dst_q  <= 2'd0;
            b_id_q   <= 4'd0;
            b_resp_q <= 2'd0;
        end else begin
            b_full_q <= b_full_d;
            b_dst_q  <= b_dst_d;
            b_id_q   <= b_id_d;
            b_resp_q <= b_resp_d;
        end
    end

    // Only the stored destination's ready can free the R stage.
    always_comb begin
        r_dst_rdy_s = 1'b0;
        case (r_dst_q)
            2'd0:    r_dst_rdy_s = rready_m1;
            2'd1:    r_dst_rdy_s = rready_m2;
            2'd2:    r_dst_rdy_s = rready_m3;
            2'd3:    r_dst_rdy_s = rready_m4;
            default: r_dst_rdy_s = 1'b0;
        endcase
    end

    assign r_drain_s = r_full_q & r_dst_rdy_s;
    assign rready_s  = ~r_full_q | r_dst_rdy_s;
    assign r_cap_s   = rvalid_s & rready_s;

    // R stage next state.
    always_comb begin
        r_full_d = r_full_q;
        r_dst_d  = r_dst_q;
        r_id_d   = r_id_q;
        r_data_d = r_data_q;
        r_resp_d = r_resp_q;
        r_last_d = r_last_q;
        if (r_cap_s) begin
            r_full_d = 1'b1;
            r_dst_d  = rid_s[5:4];
            r_id_d   = rid_s[3:0];
            r_data_d = rdata_s;
            r_resp_d = rresp_s;
            r_last_d = rlast_s;
        end else if (r_drain_s) begin
            r_full_d = 1'b0;
        end else begin
            r_full_d = r_full_q;
        end
    end

    // R stage register.
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            r_full_q <= 1'b0;
            r_dst_q  <= 2'd0;
            r_id_q   <= 4'd0;
            r_data_q <= {DATA_W{1'b0}};
            r_resp_q <= 2'd0;
            r_last_q <= 1'b0;
        end else begin
            r_full_q <= r_full_d;
            r_dst_q  <= r_dst_d;
            r_id_q   <= r_id_d;
            r_data_q <= r_data_d;
            r_resp_q <= r_resp_d;
            r_last_q <= r_last_d;
        end
    end

    // Payload fans out to every master unqualified; only valid selects the owner.
    assign bvalid_m1 = b_full_q & (b_dst_q == 2'd0);
    assign bvalid_m2 = b_full_q & (b_dst_q == 2'd1);
    assign bvalid_m3 = b_full_q & (b_dst_q == 2'd2);
    assign bvalid_m4 = b_full_q & (b_dst_q == 2'd3);
    assign bid_m1 = b_id_q;  assign bresp_m1 = b_resp_q;
    assign bid_m2 = b_id_q;  assign bresp_m2 = b_resp_q;
    assign bid_m3 = b_id_q;  assign bresp_m3 = b_resp_q;
    assign bid_m4 = b_id_q;  assign bresp_m4 = b_resp_q;

    assign rvalid_m1 = r_full_q & (r_dst_q == 2'd0);
    assign rvalid_m2 = r_full_q & (r_dst_q == 2'd1);
    assign rvalid_m3 = r_full_q & (r_dst_q == 2'd2);
    assign rvalid_m4 = r_full_q & (r_dst_q == 2'd3);
    assign rid_m1 = r_id_q;  assign rdata_m1 = r_data_q;  assign rresp_m1 = r_resp_q;  assign rlast_m1 = r_last_q;
    assign rid_m2 = r_id_q;  assign rdata_m2 = r_data_q;  assign rresp_m2 = r_resp_q;  assign rlast_m2 = r_last_q;
    assign rid_m3 = r_id_q;  assign rdata_m3 = r_data_q;  assign rresp_m3 = r_resp_q;  assign rlast_m3 = r_last_q;
    assign rid_m4 = r_id_q;  assign rdata_m4 = r_data_q;  assign rresp_m4 = r_resp_q;  assign rlast_m4 = r_last_q;
endmodule

// File: tb/tb_resp_demux_m4.sv
// Directed self-checking bench for resp_demux_m4.
// Inputs are driven 1 time unit after each rising edge, and outputs are sampled 1 time unit later.
module tb_resp_demux_m4;
    localparam int DATA_W = 32;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    resp_demux_m4_if #(.DATA_W(DATA_W)) sif ();

    logic [3:0] bid_m1, bid_m2, bid_m3, bid_m4;
    logic [1:0] bresp_m1, bresp_m2, bresp_m3, bresp_m4;
    logic       bvalid_m1, bvalid_m2, bvalid_m3, bvalid_m4;
    logic       bready_m1, bready_m2, bready_m3, bready_m4;
    logic [3:0] rid_m1, rid_m2, rid_m3, rid_m4;
    logic [DATA_W-1:0] rdata_m1, rdata_m2, rdata_m3, rdata_m4;
    logic [1:0] rresp_m1, rresp_m2, rresp_m3, rresp_m4;
    logic       rlast_m1, rlast_m2, rlast_m3, rlast_m4;
    logic       rvalid_m1, rvalid_m2, rvalid_m3, rvalid_m4;
    logic       rready_m1, rready_m2, rready_m3, rready_m4;

    always #5 aclk = ~aclk;

    resp_demux_m4 #(.DATA_W(DATA_W)) dut (
        .aclk(aclk), .areset(areset),
        .bid_s(sif.bid_s), .bresp_s(sif.bresp_s), .bvalid_s(sif.bvalid_s), .bready_s(sif.bready_s),
        .rid_s(sif.rid_s), .rdata_s(sif.rdata_s), .rresp_s(sif.rresp_s), .rlast_s(sif.rlast_s),
        .rvalid_s(sif.rvalid_s), .rready_s(sif.rready_s),
        .bid_m1(bid_m1), .bresp_m1(bresp_m1), .bvalid_m1(bvalid_m1), .bready_m1(bready_m1),
        .bid_m2(bid_m2), .bresp_m2(bresp_m2), .bvalid_m2(bvalid_m2), .bready_m2(bready_m2),
        .bid_m3(bid_m3), .bresp_m3(bresp_m3), .bvalid_m3(bvalid_m3), .bready_m3(bready_m3),
        .bid_m4(bid_m4), .bresp_m4(bresp_m4), .bvalid_m4(bvalid_m4), .bready_m4(bready_m4),
        .rid_m1(rid_m1), .rdata_m1(rdata_m1), .rresp_m1(rresp_m1), .rlast_m1(rlast_m1),
        .rvalid_m1(rvalid_m1), .rready_m1(rready_m1),
        .rid_m2(rid_m2), .rdata_m2(rdata_m2), .rresp_m2(rresp_m2), .rlast_m2(rlast_m2),
        .rvalid_m2(rvalid_m2), .rready_m2(rready_m2),
        .rid_m3(rid_m3), .rdata_m3(rdata_m3), .rresp_m3(rresp_m3), .rlast_m3(rlast_m3),
        .rvalid_m3(rvalid_m3), .rready_m3(rready_m3),
        .rid_m4(rid_m4), .rdata_m4(rdata_m4), .rresp_m4(rresp_m4), .rlast_m4(rlast_m4),
        .rvalid_m4(rvalid_m4), .rready_m4(rready_m4)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        sif.bid_s = 6'd0; sif.bresp_s = 2'd0; sif.bvalid_s = 1'b0;
        sif.rid_s = 6'd0; sif.rdata_s = 32'd0; sif.rresp_s = 2'd0; sif.rlast_s = 1'b0; sif.rvalid_s = 1'b0;
        bready_m1 = 1'b0; bready_m2 = 1'b0; bready_m3 = 1'b0; bready_m4 = 1'b0;
        rready_m1 = 1'b0; rready_m2 = 1'b0; rready_m3 = 1'b0; rready_m4 = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] vl;
        idle_inputs();
        #2 areset = 1'b0;
        #2;
        vl = {bvalid_m1, bvalid_m2, bvalid_m3, bvalid_m4, rvalid_m1, rvalid_m2, rvalid_m3, rvalid_m4};
        tests++;
        if (vl !== 8'h00) begin fails++; $display("FAIL reset_valids got %b exp 00000000", vl); end
        tests++;
        if ({sif.bready_s, sif.rready_s} !== 2'b11) begin
            fails++; $display("FAIL reset_readies got %b exp 11", {sif.bready_s, sif.rready_s});
        end
        tests++;
        if ({bid_m1, bresp_m3, rid_m4, rresp_m2, rlast_m1} !== 13'd0 || rdata_m2 !== 32'd0) begin
            fails++; $display("FAIL reset_payload got id=%h data=%h exp 0", bid_m1, rdata_m2);
        end
        @(negedge aclk);
        areset = 1'b1;
        tick();
        tests++;
        if ({bvalid_m1, rvalid_m1, sif.bready_s, sif.rready_s} !== 4'b0011) begin
            fails++; $display("FAIL post_reset got %b exp 0011", {bvalid_m1, rvalid_m1, sif.bready_s, sif.rready_s});
        end
    endtask

    task automatic test_b_single();
        idle_inputs();
        bready_m3 = 1'b1;
        sif.bid_s = 6'b10_0101; sif.bresp_s = 2'b10; sif.bvalid_s = 1'b1;
        tick();
        sif.bvalid_s = 1'b0;
        #1;
        tests++;
        if ({bvalid_m1, bvalid_m2, bvalid_m3, bvalid_m4} !== 4'b0010 || bid_m3 !== 4'h5 || bresp_m3 !== 2'b10) begin
            fails++; $display("FAIL b_single_deliver got v=%b id=%h resp=%b exp v=0010 id=5 resp=10",
                              {bvalid_m1, bvalid_m2, bvalid_m3, bvalid_m4}, bid_m3, bresp_m3);
        end
        tick();
        tests++;
        if (bvalid_m3 !== 1'b0) begin fails++; $display("FAIL b_single_clear got %b exp 0", bvalid_m3); end
    endtask

    task automatic test_r_burst();
        idle_inputs();
        rready_m2 = 1'b1;
        sif.rid_s = 6'b01_0011; sif.rvalid_s = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                sif.rdata_s = 32'h10 + 32'(i);
                sif.rlast_s = (i == 3) ? 1'b1 : 1'b0;
                sif.rresp_s = 2'(i);
            end else begin
                sif.rvalid_s = 1'b0;
            end
            if (i > 0) begin
                #1;
                tests++;
                if (rvalid_m2 !== 1'b1 || rvalid_m1 !== 1'b0 || rdata_m2 !== 32'h10 + 32'(i - 1) ||
                    rlast_m2 !== ((i == 4) ? 1'b1 : 1'b0) || rid_m2 !== 4'h3 || rresp_m2 !== 2'(i - 1)) begin
                    fails++; $display("FAIL r_burst_beat%0d got v=%b data=%h last=%b resp=%b exp v=1 data=%h last=%b",
                                      i - 1, rvalid_m2, rdata_m2, rlast_m2, rresp_m2, 32'h10 + 32'(i - 1), (i == 4));
                end
            end
            tick();
        end
        tests++;
        if (rvalid_m2 !== 1'b0) begin fails++; $display("FAIL r_burst_end got %b exp 0", rvalid_m2); end
    endtask

    task automatic test_r_stall();
        idle_inputs();
        rready_m1 = 1'b1;
        sif.rid_s = 6'b11_0111; sif.rdata_s = 32'hA5A5_0004; sif.rlast_s = 1'b1; sif.rvalid_s = 1'b1;
        tick();
        sif.rdata_s = 32'hDEAD_BEEF; sif.rid_s = 6'b00_0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (rvalid_m4 !== 1'b1 || rvalid_m1 !== 1'b0 || sif.rready_s !== 1'b0 ||
                rdata_m4 !== 32'hA5A5_0004 || rid_m4 !== 4'h7) begin
                fails++; $display("FAIL r_stall_c%0d got v4=%b v1=%b rdy=%b data=%h exp 1 0 0 a5a50004",
                                  i, rvalid_m4, rvalid_m1, sif.rready_s, rdata_m4);
            end
            if (i == 2) begin
                sif.rvalid_s = 1'b0;
                rready_m4 = 1'b1;
            end
            tick();
        end
        tests++;
        if (rvalid_m4 !== 1'b0 || rvalid_m1 !== 1'b0 || sif.rready_s !== 1'b1) begin
            fails++; $display("FAIL r_stall_drain got v4=%b v1=%b rdy=%b exp 0 0 1", rvalid_m4, rvalid_m1, sif.rready_s);
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        bready_m1 = 1'b1; bready_m2 = 1'b1;
        sif.bid_s = 6'b00_0001; sif.bresp_s = 2'b01; sif.bvalid_s = 1'b1;
        tick();
        sif.bid_s = 6'b01_0010; sif.bresp_s = 2'b11;
        #1;
        tests++;
        if ({bvalid_m1, bvalid_m2} !== 2'b10 || bid_m1 !== 4'h1 || bresp_m1 !== 2'b01) begin
            fails++; $display("FAIL b2b_first got v=%b id=%h resp=%b exp v=10 id=1 resp=01",
                              {bvalid_m1, bvalid_m2}, bid_m1, bresp_m1);
        end
        tick();
        sif.bvalid_s = 1'b0;
        #1;
        tests++;
        if ({bvalid_m1, bvalid_m2} !== 2'b01 || bid_m2 !== 4'h2 || bresp_m2 !== 2'b11) begin
            fails++; $display("FAIL b2b_second got v=%b id=%h resp=%b exp v=01 id=2 resp=11",
                              {bvalid_m1, bvalid_m2}, bid_m2, bresp_m2);
        end
        tick();
        tests++;
        if ({bvalid_m1, bvalid_m2} !== 2'b00) begin
            fails++; $display("FAIL b2b_dup got %b exp 00", {bvalid_m1, bvalid_m2});
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        sif.rid_s = 6'b00_1001; sif.rdata_s = 32'h1234_5678; sif.rvalid_s = 1'b1;
        tick();
        sif.rvalid_s = 1'b0;
        #1;
        tests++;
        if (rvalid_m1 !== 1'b1 || sif.rready_s !== 1'b0) begin
            fails++; $display("FAIL rst_mid_pre got v=%b rdy=%b exp 1 0", rvalid_m1, sif.rready_s);
        end
        #1 areset = 1'b0;
        #1;
        tests++;
        if (rvalid_m1 !== 1'b0 || sif.rready_s !== 1'b1 || rdata_m1 !== 32'd0) begin
            fails++; $display("FAIL rst_mid_async got v=%b rdy=%b data=%h exp 0 1 0", rvalid_m1, sif.rready_s, rdata_m1);
        end
        #2 areset = 1'b1;
        rready_m1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (rvalid_m1 !== 1'b0) begin fails++; $display("FAIL rst_mid_stale%0d got %b exp 0", i, rvalid_m1); end
        end
    endtask

    task automatic test_channel_isolation();
        idle_inputs();
        rready_m1 = 1'b1;
        sif.bid_s = 6'b01_1100; sif.bresp_s = 2'b11; sif.bvalid_s = 1'b1;
        sif.rid_s = 6'b00_0110; sif.rvalid_s = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) sif.rdata_s = 32'hC0 + 32'(i);
            else sif.rvalid_s = 1'b0;
            if (i == 1) sif.bvalid_s = 1'b0;
            if (i > 0) begin
                #1;
                tests++;
                if (rvalid_m1 !== 1'b1 || rdata_m1 !== 32'hC0 + 32'(i - 1) || bvalid_m2 !== 1'b1 ||
                    bid_m2 !== 4'hC || sif.bready_s !== 1'b0) begin
                    fails++; $display("FAIL iso_c%0d got rv=%b data=%h bv=%b brdy=%b exp 1 %h 1 0",
                                      i, rvalid_m1, rdata_m1, bvalid_m2, sif.bready_s, 32'hC0 + 32'(i - 1));
                end
            end
            tick();
        end
        bready_m2 = 1'b1;
        tick();
        tests++;
        if (bvalid_m2 !== 1'b0 || rvalid_m1 !== 1'b0) begin
            fails++; $display("FAIL iso_drain got bv=%b rv=%b exp 0 0", bvalid_m2, rvalid_m1);
        end
    endtask

    initial begin
        test_reset();
        test_b_single();
        test_r_burst();
        test_r_stall();
        test_back_to_back();
        test_reset_mid();
        test_channel_isolation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/resp_demux_m4.md
RESP_DEMUX_M4 -- requirements
Module: resp_demux_m4

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the R-channel data width.
REQ-002 SHALL have port aclk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port areset, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have slave B-channel ports: bid_s input 6 (bits [5:4] are the master index, bits [3:0] the master ID); bresp_s input 2; bvalid_s input 1; bready_s output 1.
REQ-005 SHALL have slave R-channel ports: rid_s input 6 (same split as bid_s); rdata_s input DATA_W; rresp_s input 2; rlast_s input 1; rvalid_s input 1; rready_s output 1.
REQ-006 SHALL have, for each master N=1..4, B-channel ports: bid_mN output 4; bresp_mN output 2; bvalid_mN output 1; bready_mN input 1.
REQ-007 SHALL have, for each master N=1..4, R-channel ports: rid_mN output 4; rdata_mN output DATA_W; rresp_mN output 2; rlast_mN output 1; rvalid_mN output 1; rready_mN input 1.

Function
REQ-008 SHALL route the B and R channels independently, each through one single-entry register stage holding a full flag, a 2-bit destination, a 4-bit ID and the payload.
REQ-009 SHALL decode destination from id[5:4]: 00->m1, 01->m2, 10->m3, 11->m4.
REQ-010 SHALL capture a beat when valid_s & ready_s: store the destination, id[3:0] and payload (resp; rdata/rlast for R), and set full.
REQ-011 SHALL drive ready_s = !full | ready of the currently stored destination master.
REQ-012 SHALL assert valid_mN only when full and the stored destination equals N; all other masters' valid SHALL be 0.
REQ-013 SHALL drive id_mN and payload_mN for every master from the register stage; only the valid qualifies them.
REQ-014 SHALL clear full when the destination master's valid & ready are both high and no new beat is captured in the same cycle.
REQ-015 SHALL, on a simultaneous drain and capture, overwrite the stage with the new beat, keep full=1, and lose no beat.
REQ-016 SHALL have a latency of exactly one cycle from slave handshake to valid_mN; sustained throughput SHALL be one beat per cycle when the destination keeps ready high.
REQ-017 SHALL hold valid, ID and payload stable toward a master while it stalls, and SHALL deassert slave-side ready when full and that master is stalled.
REQ-018 SHALL not let a stalled master's ready or valid affect the other channel, and SHALL ignore ready from non-destination masters.
REQ-019 SHALL pass rlast through per beat unchanged, with no burst-length checking.
REQ-020 SHALL forward resp values (OKAY/EXOKAY/SLVERR/DECERR) unmodified.

Reset
REQ-021 SHALL, while areset=0, immediately clear both full flags, making all bvalid_mN and rvalid_mN 0 asynchronously.
REQ-022 SHALL reset stored ID, destination and payload registers to 0, so all bid_mN/rid_mN/resp/rdata/rlast outputs read 0.
REQ-023 SHALL drive bready_s=1 and rready_s=1 during and after reset, because the stage is empty.
REQ-024 SHALL, when reset is asserted mid-transfer, discard any buffered beat; after release, a master SHALL see no stale valid.

Verification
REQ-025 SHALL verify: bid_s=6'b10_0101, bresp_s=2'b10, bvalid_s=1 for one cycle, bready_m3=1 -> next cycle bvalid_m3=1, bid_m3=4'h5, bresp_m3=2'b10; other bvalid=0; one cycle later bvalid_m3=0.
REQ-026 SHALL verify: 4-beat R burst, rid_s=6'b01_0011, rdata 0x10..0x13, rlast on beat 4, rready_m2 held 1 -> rvalid_m2 high for 4 consecutive cycles starting one cycle after the first beat, rlast_m2 only on the 0x13 beat.
REQ-027 SHALL verify: R beat to m4 with rready_m4=0 for 3 cycles -> rready_s=0 after capture, rdata_m4 stable for 3 cycles; rready_m1=1 has no effect; the beat drains in the cycle rready_m4 rises.
REQ-028 SHALL verify: back-to-back B beats to m1 then m2, both readies high -> bvalid_m1 in cycle n+1 and bvalid_m2 in cycle n+2, with no gap and no duplicate.
REQ-029 SHALL verify: areset pulled low while rvalid_m1=1 is stalled -> rvalid_m1=0 in the same cycle, rready_s=1, and nothing is delivered after release until a new rvalid_s.
REQ-030 SHALL verify: B stalled toward m2 while R to m1 streams -> the R channel runs at full rate, unaffected.
